// File: rtl/array_mul_pkg.sv
// Shared definitions for the pipelined array multiplier: legality checks,
// rows-per-stage helper and the rank record carried between pipeline ranks.
package array_mul_pkg;

   localparam int unsigned MAX_W = 32;

   function automatic bit width_legal(input int unsigned w);
      return (w >= 4) && (w <= MAX_W) && (w % 2 == 0);
   endfunction

   function automatic bit stages_legal(input int unsigned w, input int unsigned s);
      return (s >= 1) && (s <= w) && (w % s == 0);
   endfunction

   function automatic int unsigned rows_per_stage(input int unsigned w, input int unsigned s);
      return w / s;
   endfunction

   // Sized for the widest legal operand; narrower instances leave upper bits zero.
   typedef struct packed {
      logic               vld;
      logic               tc;
      logic [MAX_W-1:0]   a;
      logic [MAX_W-1:0]   b;
      logic [2*MAX_W-1:0] psum;
   } rank_t;

   localparam int unsigned RANK_W = $bits(rank_t);

endpackage

// File: rtl/array_mul_stage.sv
// One pipeline rank: adds ROWS partial-product rows starting at row BASE to
// the running sum, then registers the rank record when enabled.
module array_mul_stage
   import array_mul_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ROWS  = 2,
   parameter int unsigned BASE  = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              en_i,
   input  logic [RANK_W-1:0] rank_i,
   output logic [RANK_W-1:0] rank_o
);

   rank_t              cur;
   rank_t              rank_d;
   rank_t              rank_q;
   logic [WIDTH-1:0]   row;
   logic [2*WIDTH-1:0] acc;

   // In signed mode the Baugh-Wooley rows complement the bits where exactly
   // one of the two operand indices is the sign position.
   always_comb begin
      cur = rank_t'(rank_i);
      row = '0;
      acc = cur.psum[2*WIDTH-1:0];
      for (int unsigned j = BASE; j < BASE + ROWS; j++) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            row[i] = (cur.a[i] & cur.b[j]) ^ (cur.tc & ((i == WIDTH-1) != (j == WIDTH-1)));
         end
         acc = acc + ((2*WIDTH)'(row) << j);
      end
      rank_d                     = cur;
      rank_d.psum                = '0;
      rank_d.psum[2*WIDTH-1:0]   = acc;
   end

   // Bubbles only clear the valid bit so the last product stays on the output.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rank_q <= '0;
      end else if (en_i) begin
         if (rank_d.vld) begin
            rank_q <= rank_d;
         end else begin
            rank_q.vld <= 1'b0;
         end
      end
   end

   assign rank_o = rank_q;

endmodule

// File: rtl/array_mul_pipe.sv
// Pipelined array multiplier, STAGES ranks of WIDTH/STAGES rows each, with a
// valid/ready handshake. Define ARRAY_MUL_SIGNED_EN to add the tc port.
module array_mul_pipe
   import array_mul_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mlier,
`ifdef ARRAY_MUL_SIGNED_EN
   input  logic               tc,
`endif
   output logic               in_ready,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] prodt,
   output logic               valid
);

   localparam int unsigned RPS = rows_per_stage(WIDTH, STAGES);

   if (!width_legal(WIDTH) || !stages_legal(WIDTH, STAGES)) begin : g_param_err
      $error("array_mul_pipe: illegal WIDTH/STAGES combination");
   end

   logic              tc_s;
   rank_t             head;
   rank_t             tail;
   logic [RANK_W-1:0] chain [STAGES+1];
   logic              unused_tail;

`ifdef ARRAY_MUL_SIGNED_EN
   assign tc_s = tc;
`else
   assign tc_s = 1'b0;
`endif

   // Baugh-Wooley correction constants (2^WIDTH + 2^(2*WIDTH-1)) seed the sum.
   always_comb begin
      head      = '0;
      head.vld  = start;
      head.tc   = tc_s;
      head.a    = MAX_W'(mcand);
      head.b    = MAX_W'(mlier);
      if (tc_s) begin
         head.psum[WIDTH]       = 1'b1;
         head.psum[2*WIDTH-1]   = 1'b1;
      end
   end

   assign chain[0] = head;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      array_mul_stage #(
         .WIDTH (WIDTH),
         .ROWS  (RPS),
         .BASE  (s * RPS)
      ) u_stage (
         .clock  (clock),
         .reset  (reset),
         .en_i   (in_ready),
         .rank_i (chain[s]),
         .rank_o (chain[s+1])
      );
   end

   assign tail        = rank_t'(chain[STAGES]);
   assign valid       = tail.vld;
   assign prodt       = tail.psum[2*WIDTH-1:0];
   assign in_ready    = !(valid && !out_ready);
   assign unused_tail = ^tail;

endmodule
